frame_cmd_sched: RTL and testbench
==================================

Name: frame_cmd_sched

Overview:
- Command scheduler between the UART receive front end and the SD image loader.
- Consumes received bytes over a valid/ready handshake and decodes single-character commands.
- Keeps the current picture index with wrap-around and runs an optional slideshow timer.
- Issues one image-load request at a time to the loader, and back-pressures the UART while a load is in flight.

Parameters:
IDX_W, 8, width of image index and image count
CLK_FREQ, 4000000, clock frequency in Hz
SLIDE_SEC, 10, slideshow period in seconds; timer terminal count = CLK_FREQ*SLIDE_SEC-1 (32-bit counter)
SLIDE_EN_RST, 1, slideshow_en value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
rx_data  in  8  received byte, stable while rx_valid high
rx_valid  in  1  received byte available
rx_ready  out  1  byte accepted on cycle where rx_valid & rx_ready
card_ready  in  1  SD card initialised; img_count valid
img_count  in  IDX_W  number of images on card (0 = none)
load_req  out  1  load request, level, held until load_done
load_idx  out  IDX_W  index to load, stable while load_req high
load_done  in  1  single-cycle pulse, loader finished
cur_idx  out  IDX_W  index of last successfully loaded image
slideshow_en  out  1  slideshow timer enabled
cmd_err  out  1  one-cycle pulse, rejected command

Behaviour:
- Reset: synchronous on rising clk while rst_n=0, and aborts any state including mid-load or mid-argument.
  - Reset values: state=BOOT, load_req=0, load_idx=0, cur_idx=0, cmd_err=0, slideshow_en=SLIDE_EN_RST, timer=0.
  - A pending load_done after reset is ignored.
- rx_ready is a combinational decode of state: 1 in IDLE and ARG, 0 in BOOT and LOAD.
- State BOOT:
  - Wait for card_ready=1.
  - If img_count>0: load_idx<=0, load_req<=1, go to LOAD.
  - Else go to IDLE.
- State IDLE: on an accepted byte, act on that byte:
  - '+' (0x2B): next = (cur_idx+1 >= img_count) ? 0 : cur_idx+1.
  - '-' (0x2D): next = (cur_idx==0 || cur_idx>=img_count) ? img_count-1 : cur_idx-1.
  - 'r' (0x72): reload; next = cur_idx.
  - 'g' (0x67): go to ARG.
  - 'p' (0x70): toggle slideshow_en, clear timer, stay in IDLE.
  - Any other byte: cmd_err pulse, stay in IDLE.
  - For '+', '-' and 'r' with img_count>0: load_idx<=next, load_req<=1, go to LOAD.
  - For '+', '-' and 'r' with img_count==0: cmd_err pulse, stay in IDLE.
- State ARG:
  - The next accepted byte is a raw binary index (low IDX_W bits used; upper bits must be 0).
  - If the index is less than img_count: load it, go to LOAD.
  - Otherwise: cmd_err pulse, go to IDLE.
  - No timeout.
- State LOAD:
  - load_req=1 with load_idx held.
  - On load_done: cur_idx<=load_idx, load_req<=0, timer<=0, go to IDLE.
  - load_done outside LOAD is ignored.
- Latency: byte accepted at edge N gives load_req=1 (or cmd_err=1) during cycle N+1. load_done at edge M gives load_req=0 and the updated cur_idx during cycle M+1.
- Slideshow timer:
  - Increments only in IDLE with slideshow_en=1 and img_count>0.
  - At terminal count it clears and behaves exactly like '+'.
  - It holds its value in other states and is cleared on every load completion.
- Simultaneous events: a byte accepted on the same cycle as timer terminal count takes priority. The timer clears and the byte's command executes; no double load.
- cmd_err is high for exactly one cycle per rejected byte.
- img_count is sampled only when computing next; changes during LOAD do not affect the load in flight.
- Wrap arithmetic is IDX_W-bit unsigned.

Test Plan:
- Boot: card_ready=1, img_count=5 -> load_req=1, load_idx=0. Pulse load_done -> cur_idx=0, load_req=0, rx_ready=1.
- Wrap: cur_idx=4, img_count=5, send '+' -> load_idx=0. Then send '-' -> load_idx=4. rx_ready=0 throughout LOAD until load_done.
- Goto: send 'g' then 0x03 with img_count=5 -> load_idx=3. Send 'g' then 0x07 -> cmd_err pulse, no load_req, state IDLE.
- Errors: img_count=0, send '+' -> cmd_err one cycle, load_req stays 0. Send 'x' -> cmd_err, no state change.
- Slideshow: CLK_FREQ=10, SLIDE_SEC=1, cur_idx=1 -> load_req with load_idx=2 ten cycles after entering IDLE. Send 'p' -> slideshow_en=0, no further auto loads. Byte on the terminal-count cycle -> exactly one load.
- Reset mid-load: rst_n=0 for 1 cycle while load_req=1 -> load_req=0, cur_idx=0, state BOOT. A later load_done is ignored.

Source files
------------

// File: rtl/frame_cmd_if.sv
// Byte-stream and loader handshake bundle between the UART front end, the
// frame command scheduler and the SD image loader.
interface frame_cmd_if #(
   parameter int IDX_W = 8
);
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             card_ready;
   logic [IDX_W-1:0] img_count;
   logic             load_req;
   logic [IDX_W-1:0] load_idx;
   logic             load_done;
   logic [IDX_W-1:0] cur_idx;
   logic             slideshow_en;
   logic             cmd_err;

   modport master (
      output rx_data, rx_valid, card_ready, img_count, load_done,
      input  rx_ready, load_req, load_idx, cur_idx, slideshow_en, cmd_err
   );

   modport slave (
      input  rx_data, rx_valid, card_ready, img_count, load_done,
      output rx_ready, load_req, load_idx, cur_idx, slideshow_en, cmd_err
   );
endinterface

// File: rtl/frame_cmd_sched.sv
// Picture-frame command scheduler: decodes UART command bytes, tracks the
// current image index, runs the slideshow timer and issues one load at a time.
//
// state  | meaning
// S_BOOT | waiting for card_ready, then loads image 0 if the card has images
// S_IDLE | accepting command bytes, slideshow timer running
// S_ARG  | next byte is the raw index for a goto command
// S_LOAD | load_req held until load_done
module frame_cmd_sched #(
   parameter int IDX_W        = 8,
   parameter int CLK_FREQ     = 4000000,
   parameter int SLIDE_SEC    = 10,
   parameter bit SLIDE_EN_RST = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   frame_cmd_if.slave bus
);
   localparam logic [31:0] TIMER_TC  = 32'(CLK_FREQ * SLIDE_SEC - 1);
   localparam logic [7:0]  CH_PLUS   = 8'h2B;
   localparam logic [7:0]  CH_MINUS  = 8'h2D;
   localparam logic [7:0]  CH_RELOAD = 8'h72;
   localparam logic [7:0]  CH_GOTO   = 8'h67;
   localparam logic [7:0]  CH_PAUSE  = 8'h70;

   typedef enum logic [1:0] {S_BOOT, S_IDLE, S_ARG, S_LOAD} state_t;

   state_t           state_q;
   logic             load_req_q;
   logic [IDX_W-1:0] load_idx_q;
   logic [IDX_W-1:0] cur_idx_q;
   logic             slide_en_q;
   logic             cmd_err_q;
   logic [31:0]      timer_q;

   logic             rx_acc;
   logic             cnt_nz;
   logic             slide_ok;
   logic             tick_hit;
   logic             arg_ok;
   logic [IDX_W-1:0] idx_inc;
   logic [IDX_W-1:0] idx_plus;
   logic [IDX_W-1:0] idx_minus;
   logic [IDX_W+7:0] arg_wide;
   logic             load_d;
   logic             err_d;
   logic             toggle_d;
   logic [IDX_W-1:0] load_idx_d;

   assign bus.rx_ready     = (state_q == S_IDLE) || (state_q == S_ARG);
   assign bus.load_req     = load_req_q;
   assign bus.load_idx     = load_idx_q;
   assign bus.cur_idx      = cur_idx_q;
   assign bus.slideshow_en = slide_en_q;
   assign bus.cmd_err      = cmd_err_q;

   assign rx_acc    = bus.rx_valid && bus.rx_ready;
   assign cnt_nz    = (bus.img_count != '0);
   assign slide_ok  = (state_q == S_IDLE) && slide_en_q && cnt_nz;
   assign tick_hit  = slide_ok && (timer_q == TIMER_TC);
   assign idx_inc   = cur_idx_q + 1'b1;
   assign idx_plus  = (idx_inc >= bus.img_count) ? '0 : idx_inc;
   assign idx_minus = ((cur_idx_q == '0) || (cur_idx_q >= bus.img_count)) ?
                      bus.img_count - 1'b1 : cur_idx_q - 1'b1;
   // Widened compare also rejects set bits above IDX_W when IDX_W < 8.
   assign arg_wide  = {{IDX_W{1'b0}}, bus.rx_data};
   assign arg_ok    = arg_wide < {8'h00, bus.img_count};

   always_comb begin
      load_d     = 1'b0;
      err_d      = 1'b0;
      toggle_d   = 1'b0;
      load_idx_d = '0;
      case (state_q)
         S_BOOT: load_d = bus.card_ready && cnt_nz;
         S_IDLE: begin
            if (rx_acc) begin
               case (bus.rx_data)
                  CH_PLUS: begin
                     load_d     = cnt_nz;
                     err_d      = !cnt_nz;
                     load_idx_d = idx_plus;
                  end
                  CH_MINUS: begin
                     load_d     = cnt_nz;
                     err_d      = !cnt_nz;
                     load_idx_d = idx_minus;
                  end
                  CH_RELOAD: begin
                     load_d     = cnt_nz;
                     err_d      = !cnt_nz;
                     load_idx_d = cur_idx_q;
                  end
                  CH_GOTO:  ;
                  CH_PAUSE: toggle_d = 1'b1;
                  default:  err_d = 1'b1;
               endcase
            end else if (tick_hit) begin
               load_d     = 1'b1;
               load_idx_d = idx_plus;
            end
         end
         S_ARG: begin
            if (rx_acc) begin
               load_d     = arg_ok;
               err_d      = !arg_ok;
               load_idx_d = arg_wide[IDX_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         load_req_q <= 1'b0;
         load_idx_q <= '0;
         cur_idx_q  <= '0;
         cmd_err_q  <= 1'b0;
         slide_en_q <= SLIDE_EN_RST;
         timer_q    <= '0;
      end else begin
         cmd_err_q <= err_d;
         if (load_d) begin
            load_req_q <= 1'b1;
            load_idx_q <= load_idx_d;
            state_q    <= S_LOAD;
         end
         if (toggle_d) slide_en_q <= !slide_en_q;
         case (state_q)
            S_BOOT: if (bus.card_ready && !cnt_nz) state_q <= S_IDLE;
            S_IDLE: begin
               // A byte on the terminal-count cycle still clears the timer.
               if (slide_ok) timer_q <= tick_hit ? '0 : timer_q + 1'b1;
               if (toggle_d) timer_q <= '0;
               if (rx_acc && (bus.rx_data == CH_GOTO)) state_q <= S_ARG;
            end
            S_ARG: if (rx_acc && !arg_ok) state_q <= S_IDLE;
            S_LOAD: begin
               if (bus.load_done) begin
                  cur_idx_q  <= load_idx_q;
                  load_req_q <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_cmd_sched.sv
// Randomised scoreboard bench for frame_cmd_sched with a short slideshow
// period so timer-driven loads occur frequently.
module tb_frame_cmd_sched;
   localparam int IDX_W     = 8;
   localparam int CLK_FREQ  = 10;
   localparam int SLIDE_SEC = 1;
   localparam int TC        = CLK_FREQ * SLIDE_SEC - 1;
   localparam int M_BOOT = 0, M_IDLE = 1, M_ARG = 2, M_LOAD = 3;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   ev_t  load_q[$];
   ev_t  fall_q[$];
   ev_t  err_q[$];
   ev_t  ev;

   int   m_state = M_BOOT;
   int   m_cur   = 0;
   int   m_idx   = 0;
   int   m_tick  = 0;
   bit   m_en    = 1'b1;
   bit   prev_req = 1'b0;

   frame_cmd_if #(.IDX_W(IDX_W)) bus ();

   frame_cmd_sched #(
      .IDX_W(IDX_W), .CLK_FREQ(CLK_FREQ), .SLIDE_SEC(SLIDE_SEC), .SLIDE_EN_RST(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at cycle %0d", name, got, want, cyc);
      end
   endfunction

   function automatic void flag(string name, int got);
      checks++;
      errors++;
      $display("FAIL %s got %0d want none at cycle %0d", name, got, cyc);
   endfunction

   function automatic void start_load(int v);
      load_q.push_back('{cyc + 1, v});
      m_idx   = v;
      m_state = M_LOAD;
   endfunction

   function automatic void expect_err();
      err_q.push_back('{cyc + 1, 0});
   endfunction

   // Reference behaviour, evaluated once per rising edge from the driven inputs.
   function automatic void model_step();
      int cnt, d, plus, minus;
      bit acc, elig, fire;
      cnt = int'(bus.img_count);
      d   = int'(bus.rx_data);
      if (!rst_n) begin
         if (m_state == M_LOAD) fall_q.push_back('{cyc + 1, 0});
         m_state = M_BOOT; m_cur = 0; m_idx = 0; m_tick = 0; m_en = 1'b1;
         return;
      end
      plus  = (m_cur + 1 >= cnt) ? 0 : m_cur + 1;
      minus = (m_cur == 0 || m_cur >= cnt) ? cnt - 1 : m_cur - 1;
      acc   = bus.rx_valid && (m_state == M_IDLE || m_state == M_ARG);
      case (m_state)
         M_BOOT: begin
            if (bus.card_ready) begin
               if (cnt > 0) start_load(0);
               else m_state = M_IDLE;
            end
         end
         M_IDLE: begin
            elig = m_en && cnt > 0;
            fire = elig && m_tick == TC;
            if (elig) m_tick = fire ? 0 : m_tick + 1;
            if (acc) begin
               case (d)
                  'h2B: if (cnt > 0) start_load(plus); else expect_err();
                  'h2D: if (cnt > 0) start_load(minus); else expect_err();
                  'h72: if (cnt > 0) start_load(m_cur); else expect_err();
                  'h67: m_state = M_ARG;
                  'h70: begin m_en = !m_en; m_tick = 0; end
                  default: expect_err();
               endcase
            end else if (fire) begin
               start_load(plus);
            end
         end
         M_ARG: begin
            if (acc) begin
               if (d < cnt) start_load(d);
               else begin expect_err(); m_state = M_IDLE; end
            end
         end
         default: begin
            if (bus.load_done) begin
               m_cur = m_idx; m_tick = 0; m_state = M_IDLE;
               fall_q.push_back('{cyc + 1, m_idx});
            end
         end
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
      cyc++;
   end

   // Monitor: pops scoreboard entries as the DUT presents events.
   initial forever begin
      @(negedge clk);
      if (bus.load_req && !prev_req) begin
         if (load_q.size() == 0) flag("load_unexpected", int'(bus.load_idx));
         else begin
            ev = load_q.pop_front();
            check("load_cycle", cyc, ev.cyc);
            check("load_idx", int'(bus.load_idx), ev.val);
         end
      end
      if (!bus.load_req && prev_req) begin
         if (fall_q.size() == 0) flag("load_fall_unexpected", int'(bus.cur_idx));
         else begin
            ev = fall_q.pop_front();
            check("done_cycle", cyc, ev.cyc);
            check("done_cur_idx", int'(bus.cur_idx), ev.val);
         end
      end
      if (bus.cmd_err) begin
         if (err_q.size() == 0) flag("cmd_err_unexpected", 1);
         else begin
            ev = err_q.pop_front();
            check("cmd_err_cycle", cyc, ev.cyc);
         end
      end
      while (load_q.size() > 0 && load_q[0].cyc <= cyc) begin
         ev = load_q.pop_front();
         check("load_missing", 0, 1);
      end
      while (fall_q.size() > 0 && fall_q[0].cyc <= cyc) begin
         ev = fall_q.pop_front();
         check("done_missing", 0, 1);
      end
      while (err_q.size() > 0 && err_q[0].cyc <= cyc) begin
         ev = err_q.pop_front();
         check("cmd_err_missing", 0, 1);
      end
      check("rx_ready", int'(bus.rx_ready), int'(m_state == M_IDLE || m_state == M_ARG));
      check("load_req", int'(bus.load_req), int'(m_state == M_LOAD));
      check("slideshow_en", int'(bus.slideshow_en), int'(m_en));
      check("cur_idx", int'(bus.cur_idx), m_cur);
      if (m_state == M_LOAD) check("load_idx_hold", int'(bus.load_idx), m_idx);
      prev_req = bus.load_req;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      int k;
      k = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) check("send_timeout", k, 0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!bus.load_req && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("load_req_timeout", k, 0);
   endtask

   task automatic finish_load();
      wait_req();
      bus.load_done = 1'b1;
      @(negedge clk);
      bus.load_done = 1'b0;
   endtask

   initial begin
      int k, r;
      bus.rx_valid   = 1'b0;
      bus.rx_data    = 8'h00;
      bus.card_ready = 1'b0;
      bus.img_count  = 8'd5;
      bus.load_done  = 1'b0;
      rst_n          = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      bus.card_ready = 1'b1;
      finish_load();
      send(8'h2B);
      finish_load();
      finish_load();
      send(8'h70);
      tick(30);
      send(8'h67); send(8'h04); finish_load();
      send(8'h2B); finish_load();
      send(8'h2D); finish_load();
      send(8'h67); send(8'h03); finish_load();
      send(8'h67); send(8'h07);
      tick(3);
      bus.img_count = 8'd0;
      send(8'h2B);
      send(8'h78);
      tick(3);
      bus.img_count = 8'd5;
      send(8'h70);
      k = 0;
      while (!(m_state == M_IDLE && m_tick == TC) && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (k >= 40) check("tc_wait_timeout", k, 0);
      bus.rx_data  = 8'h72;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      finish_load();
      send(8'h72);
      wait_req();
      bus.card_ready = 1'b0;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      bus.load_done = 1'b1;
      tick(1);
      bus.load_done = 1'b0;
      tick(2);
      bus.card_ready = 1'b1;
      finish_load();

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 11));
         case (r)
            0: bus.rx_data = 8'h2B;
            1: bus.rx_data = 8'h2D;
            2: bus.rx_data = 8'h72;
            3: bus.rx_data = 8'h67;
            4: bus.rx_data = 8'h70;
            5: bus.rx_data = 8'h78;
            default: bus.rx_data = 8'($urandom_range(0, 7));
         endcase
         bus.rx_valid  = ($urandom_range(0, 1) == 0);
         bus.load_done = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) bus.img_count = 8'($urandom_range(0, 6));
         bus.card_ready = ($urandom_range(0, 19) != 0);
         rst_n = ($urandom_range(0, 399) != 0);
         @(negedge clk);
      end
      bus.rx_valid  = 1'b0;
      bus.load_done = 1'b0;
      rst_n         = 1'b1;
      tick(5);
      check("load_q_left", load_q.size(), 0);
      check("fall_q_left", fall_q.size(), 0);
      check("err_q_left", err_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
